// File: rtl/minority_detector.sv
// -----------------------------------------------------------------------------
// minority_detector
//   Registered minority-vote detector. dout is 1 when strictly fewer than half
//   of the din bits are set (2*ones(din) < N). For even N a tie is not a
//   minority. One flop stage on the output; latency is exactly one clock.
//
// Parameters
//   N        width of din (N >= 1)
//
// Ports (declaration order is fixed so positional binding works)
//   din      in   N  input vector to be voted
//   clock    in   1  rising-edge clock
//   dout     out  1  registered minority flag
//   reset_n  in   1  asynchronous active-low reset, clears dout
// -----------------------------------------------------------------------------
module minority_detector #(
  parameter int N = 5
) (
  input  logic [N-1:0] din,
  input  logic         clock,
  output logic         dout,
  input  logic         reset_n
);

  // Popcount width: enough to hold the value N, never less than one bit.
  localparam int CW = (N < 2) ? 1 : $clog2(N + 1);

  // N widened to CW+1 bits so the doubled popcount compares without truncation.
  localparam logic [CW:0] N_CMP = (CW + 1)'(N);

  logic [CW-1:0] ones_d;
  logic          minority_d;
  logic          dout_q;

  always_comb begin
    ones_d = '0;
    for (int i = 0; i < N; i++) begin
      ones_d = ones_d + CW'(din[i]);
    end
    // {ones,0} is 2*ones; strict less-than makes an even-N tie a non-minority.
    minority_d = ({ones_d, 1'b0} < N_CMP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= minority_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_minority_detector.sv
module tb_minority_detector;

  logic       clk;
  logic       reset_n;
  logic [4:0] din5;
  logic [3:0] din4;
  logic [0:0] din1;
  logic       dout5;
  logic       dout4;
  logic       dout1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic e5;
    logic e4;
    logic e1;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;

  minority_detector #(.N(5)) u_n5 (.din(din5), .clock(clk), .dout(dout5), .reset_n(reset_n));
  minority_detector #(.N(4)) u_n4 (.din(din4), .clock(clk), .dout(dout4), .reset_n(reset_n));
  minority_detector #(.N(1)) u_n1 (.din(din1), .clock(clk), .dout(dout1), .reset_n(reset_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count the set bits and apply the voting rule directly.
  function automatic logic model(input logic [31:0] v, input int n);
    int ones;
    ones = $countones(v);
    return (2 * ones < n);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the response
  // expected after the next rising edge.
  task automatic step(input logic r, input logic [4:0] d5, input logic [3:0] d4,
                      input logic d1, input bit glitch);
    exp_t e;
    @(negedge clk);
    reset_n = r;
    din5 = d5;
    din4 = d4;
    din1 = d1;
    e.e5 = r ? model({27'd0, d5}, 5) : 1'b0;
    e.e4 = r ? model({28'd0, d4}, 4) : 1'b0;
    e.e1 = r ? model({31'd0, d1}, 1) : 1'b0;
    exp_q.push_back(e);
    #1;
    // A din change between edges must not reach dout.
    check("hold_n5", dout5, r ? last_e.e5 : 1'b0);
    check("hold_n4", dout4, r ? last_e.e4 : 1'b0);
    if (glitch) begin
      din5 = ~d5;
      din4 = ~d4;
      din1 = ~d1;
      #1;
      din5 = d5;
      din4 = d4;
      din1 = d1;
      #1;
      check("glitch_n5", dout5, r ? last_e.e5 : 1'b0);
    end
    last_e = e;
  endtask

  // Assert reset in the middle of the high phase and require dout to clear at once.
  task automatic midcycle_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_n5", dout5, 1'b0);
    check("async_rst_n4", dout4, 1'b0);
    check("async_rst_n1", dout1, 1'b0);
    last_e = '{1'b0, 1'b0, 1'b0};
  endtask

  // Monitor: dout is presented every cycle, compare just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout_n5", dout5, e.e5);
        check("dout_n4", dout4, e.e4);
        check("dout_n1", dout1, e.e1);
      end
    end
  end

  initial begin
    logic [4:0] v5;
    logic [3:0] v4;
    logic       v1;
    reset_n = 1'b0;
    din5 = '0;
    din4 = '0;
    din1 = '0;
    last_e = '{1'b0, 1'b0, 1'b0};
    #1;
    check("reset_state_n5", dout5, 1'b0);
    check("reset_state_n4", dout4, 1'b0);
    check("reset_state_n1", dout1, 1'b0);

    // Held in reset with clocks running.
    repeat (3) step(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0);

    // Directed values and boundaries.
    step(1'b1, 5'b11101, 4'b0011, 1'b1, 1'b0);
    step(1'b1, 5'b01010, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 5'b00000, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 5'b11111, 4'b1111, 1'b0, 1'b1);
    step(1'b1, 5'b00011, 4'b0110, 1'b1, 1'b0);
    step(1'b1, 5'b00111, 4'b0111, 1'b0, 1'b1);
    step(1'b1, 5'b00000, 4'b1000, 1'b0, 1'b0);

    // Reset asserted mid-cycle, held one cycle, then released.
    midcycle_reset();
    step(1'b0, 5'b00000, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 5'b00001, 4'b1100, 1'b1, 1'b0);

    // Exhaustive N=5 sweep with a reset pulse midway; the pulsed code is repeated.
    for (int c = 0; c < 32; c++) begin
      v5 = 5'(c);
      v4 = 4'(c);
      v1 = v5[0];
      if (c == 16) begin
        step(1'b0, v5, v4, v1, 1'b0);
      end
      step(1'b1, v5, v4, v1, (c % 7) == 3);
    end

    // Randomized traffic with occasional glitches and reset cycles.
    for (int k = 0; k < 200; k++) begin
      v5 = 5'($urandom_range(0, 31));
      v4 = 4'($urandom_range(0, 15));
      v1 = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 19) != 0), v5, v4, v1, ($urandom_range(0, 4) == 0));
    end

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
      @(posedge clk);
      #2;
    end
    check("scoreboard_drained", (exp_q.size() == 0), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
